// File: rtl/pdm_cic_frontend_if.sv
// Bundles the PDM front-end run control, mic-side lines and packed PCM output.
// The front end itself is the slave side; whatever drives the mics and consumes PCM is the master.
interface pdm_cic_frontend_if #(
    parameter int NUM_MICS  = 25,
    parameter int BIT_WIDTH = 8
);
    logic                          enable;
    logic [NUM_MICS-1:0]           pdm_data;
    logic                          pdm_clk_out;
    logic [NUM_MICS*BIT_WIDTH-1:0] pcm_data_out;
    logic                          pcm_valid;
    logic                          running;

    modport master (
        output enable, pdm_data,
        input  pdm_clk_out, pcm_data_out, pcm_valid, running
    );

    modport slave (
        input  enable, pdm_data,
        output pdm_clk_out, pcm_data_out, pcm_valid, running
    );
endinterface

// File: rtl/pdm_cic_frontend.sv
// Multichannel PDM front end: drives the mic bit clock, counts ones per DECIM-bit frame
// (first-order CIC), removes the DC midpoint and emits saturated signed PCM per mic.
module pdm_cic_frontend #(
    parameter int BIT_WIDTH     = 8,
    parameter int NUM_MICS      = 25,
    parameter int CLK_DIV       = 16,
    parameter int DECIM         = 64,
    parameter int WARMUP_FRAMES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    pdm_cic_frontend_if.slave bus
);
    localparam int CNT_W   = $clog2(DECIM + 1);
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int BIT_W   = $clog2(DECIM);
    localparam int FRM_W   = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;
    localparam int SAT_MAX = (1 << (BIT_WIDTH - 1)) - 1;
    localparam int SAT_MIN = -(1 << (BIT_WIDTH - 1));
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DECIM - 1);

    typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

    state_t                        state_q, state_d;
    logic [DIV_W-1:0]              div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]              bit_cnt_q, bit_cnt_d;
    logic [FRM_W-1:0]              frame_cnt_q, frame_cnt_d;
    logic [NUM_MICS-1:0]           pdm_meta_q, pdm_sync_q;
    logic                          pdm_clk_q, pdm_clk_d;
    logic [NUM_MICS*BIT_WIDTH-1:0] pcm_q, pcm_d, frame_pcm;
    logic                          pcm_valid_q, pcm_valid_d;
    logic                          acc_clear, acc_add;
    logic                          sample_tick, frame_end;

    // Sampling at the end of the high phase gives the mics most of a half period to settle.
    assign sample_tick = (state_q != IDLE) && (div_cnt_q == DIV_LAST);
    assign frame_end   = sample_tick && (bit_cnt_q == BIT_LAST);

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        pcm_d       = pcm_q;
        pcm_valid_d = 1'b0;
        acc_clear   = 1'b0;
        acc_add     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d     = (WARMUP_FRAMES == 0) ? RUN : WARMUP;
                    div_cnt_d   = '0;
                    bit_cnt_d   = '0;
                    frame_cnt_d = '0;
                    acc_clear   = 1'b1;
                end
            end
            default: begin
                if (!bus.enable) begin
                    state_d     = IDLE;
                    div_cnt_d   = '0;
                    bit_cnt_d   = '0;
                    frame_cnt_d = '0;
                    acc_clear   = 1'b1;
                end else begin
                    div_cnt_d = sample_tick ? '0 : div_cnt_q + 1'b1;
                    if (sample_tick) begin
                        acc_add   = 1'b1;
                        bit_cnt_d = frame_end ? '0 : bit_cnt_q + 1'b1;
                    end
                    if (frame_end) begin
                        acc_clear = 1'b1;
                        if (state_q == RUN) begin
                            pcm_d       = frame_pcm;
                            pcm_valid_d = 1'b1;
                        end else if (int'(frame_cnt_q) + 1 >= WARMUP_FRAMES) begin
                            state_d     = RUN;
                            frame_cnt_d = '0;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 1'b1;
                        end
                    end
                end
            end
        endcase
        pdm_clk_d = (state_d != IDLE) && (div_cnt_d >= DIV_HALF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            pdm_meta_q  <= '0;
            pdm_sync_q  <= '0;
            pdm_clk_q   <= 1'b0;
            pcm_q       <= '0;
            pcm_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            pdm_meta_q  <= bus.pdm_data;
            pdm_sync_q  <= pdm_meta_q;
            pdm_clk_q   <= pdm_clk_d;
            pcm_q       <= pcm_d;
            pcm_valid_q <= pcm_valid_d;
        end
    end

    for (genvar gi = 0; gi < NUM_MICS; gi++) begin : g_mic
        logic [CNT_W-1:0]     cnt_q, cnt_d;
        logic [CNT_W-1:0]     total;
        logic signed [31:0]   value;
        logic [BIT_WIDTH-1:0] sat;

        // The frame-end bit is folded in here so the finished frame is complete without a stall.
        always_comb begin
            total = cnt_q + CNT_W'(pdm_sync_q[gi]);
            value = $signed(32'(total)) - 32'(DECIM / 2);
            if (value > SAT_MAX) begin
                sat = BIT_WIDTH'(SAT_MAX);
            end else if (value < SAT_MIN) begin
                sat = BIT_WIDTH'(SAT_MIN);
            end else begin
                sat = value[BIT_WIDTH-1:0];
            end
            if (acc_clear) begin
                cnt_d = '0;
            end else if (acc_add) begin
                cnt_d = total;
            end else begin
                cnt_d = cnt_q;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign frame_pcm[gi*BIT_WIDTH +: BIT_WIDTH] = sat;
    end

    assign bus.pdm_clk_out  = pdm_clk_q;
    assign bus.pcm_data_out = pcm_q;
    assign bus.pcm_valid    = pcm_valid_q;
    assign bus.running      = (state_q != IDLE);
endmodule

// File: tb/tb_pdm_cic_frontend.sv
// Two front ends (default build and a long-frame, no-warmup build) fed by behavioural mics;
// expected frames are queued from a ones-count model and checked by a separate monitor.
module tb_pdm_cic_frontend;
    localparam int NM  = 25;
    localparam int BW  = 8;
    localparam int CD  = 16;
    localparam int DC  = 64;
    localparam int WF  = 1;
    localparam int NM2 = 4;
    localparam int CD2 = 8;
    localparam int DC2 = 512;
    localparam int WF2 = 0;

    typedef struct {
        logic [NM*BW-1:0] data;
        int               cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic enable;
    int   pat0, pat1;
    int   errors = 0;
    int   checks = 0;
    exp_t q0[$];
    exp_t q1[$];

    pdm_cic_frontend_if #(.NUM_MICS(NM),  .BIT_WIDTH(BW)) if0 ();
    pdm_cic_frontend_if #(.NUM_MICS(NM2), .BIT_WIDTH(BW)) if1 ();

    assign if0.enable = enable;
    assign if1.enable = enable;

    pdm_cic_frontend #(.BIT_WIDTH(BW), .NUM_MICS(NM), .CLK_DIV(CD), .DECIM(DC),
                       .WARMUP_FRAMES(WF)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    pdm_cic_frontend #(.BIT_WIDTH(BW), .NUM_MICS(NM2), .CLK_DIV(CD2), .DECIM(DC2),
                       .WARMUP_FRAMES(WF2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NM-1:0] gen_bits(input int pat, input int idx);
        logic [NM-1:0] b;
        case (pat)
            0: b = '1;
            1: b = '0;
            2: b = idx[0] ? '0 : '1;
            3: begin b = '0; b[3] = 1'b1; end
            default: for (int i = 0; i < NM; i++) b[i] = 1'($urandom_range(0, 1));
        endcase
        return b;
    endfunction

    // Each lane: ones count minus the midpoint, clipped to the signed sample range.
    function automatic logic [NM*BW-1:0] pack_model(input int cnt[NM], input int n, input int decim);
        logic [NM*BW-1:0] r;
        int v;
        r = '0;
        for (int i = 0; i < n; i++) begin
            v = cnt[i] - decim / 2;
            if (v > (1 << (BW - 1)) - 1) v = (1 << (BW - 1)) - 1;
            if (v < -(1 << (BW - 1))) v = -(1 << (BW - 1));
            r[i*BW +: BW] = BW'(v);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [NM*BW-1:0] act, input logic [NM*BW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Mics launch a new bit just after each rising PDM clock edge they observe.
    initial begin
        int cnt0[NM];
        int cnt1[NM];
        int nb0, fr0, nb1, fr1;
        logic pc0_prev, pc1_prev;
        logic [NM-1:0] b;
        nb0 = 0; fr0 = 0; nb1 = 0; fr1 = 0;
        pc0_prev = 1'b0; pc1_prev = 1'b0;
        for (int i = 0; i < NM; i++) begin cnt0[i] = 0; cnt1[i] = 0; end
        if0.pdm_data = '0;
        if1.pdm_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !if0.running) begin
                nb0 = 0; fr0 = 0;
                for (int i = 0; i < NM; i++) cnt0[i] = 0;
            end else if (if0.pdm_clk_out && !pc0_prev) begin
                b = gen_bits(pat0, nb0);
                if0.pdm_data = b;
                for (int i = 0; i < NM; i++) cnt0[i] += int'(b[i]);
                nb0++;
                if (nb0 == DC) begin
                    fr0++;
                    if (fr0 > WF) q0.push_back('{pack_model(cnt0, NM, DC), fr0 * DC * CD});
                    nb0 = 0;
                    for (int i = 0; i < NM; i++) cnt0[i] = 0;
                end
            end
            pc0_prev = if0.pdm_clk_out;

            if (!rst_n || !if1.running) begin
                nb1 = 0; fr1 = 0;
                for (int i = 0; i < NM; i++) cnt1[i] = 0;
            end else if (if1.pdm_clk_out && !pc1_prev) begin
                b = gen_bits(pat1, nb1);
                if1.pdm_data = b[NM2-1:0];
                for (int i = 0; i < NM2; i++) cnt1[i] += int'(b[i]);
                nb1++;
                if (nb1 == DC2) begin
                    fr1++;
                    if (fr1 > WF2) q1.push_back('{pack_model(cnt1, NM2, DC2), fr1 * DC2 * CD2});
                    nb1 = 0;
                    for (int i = 0; i < NM; i++) cnt1[i] = 0;
                end
            end
            pc1_prev = if1.pdm_clk_out;
        end
    end

    // Monitor: cyc counts clocks since the front ends left IDLE.
    initial begin
        int cyc;
        logic en_prev, run_prev, exp_v;
        logic [NM*BW-1:0] hold0, hold1;
        exp_t it;
        cyc = 0; en_prev = 1'b0; run_prev = 1'b0; hold0 = '0; hold1 = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_pdm_clk", if0.pdm_clk_out, '0);
                chk("rst_valid", if0.pcm_valid, '0);
                chk("rst_running", if0.running, '0);
                chk("rst_pcm", if0.pcm_data_out, '0);
                chk("rst_pcm2", if1.pcm_data_out, '0);
                q0.delete(); q1.delete();
                hold0 = '0; hold1 = '0; en_prev = 1'b0; run_prev = 1'b0; cyc = 0;
            end else begin
                chk("running", if0.running, en_prev);
                chk("running2", if1.running, en_prev);
                if (if0.running && !run_prev) cyc = 0;
                else cyc++;
                if (!if0.running) begin q0.delete(); q1.delete(); end
                chk("pdm_clk", if0.pdm_clk_out, if0.running && ((cyc % CD) >= CD / 2));

                exp_v = (q0.size() != 0) && (q0[0].cyc == cyc);
                chk("valid", if0.pcm_valid, exp_v);
                if (exp_v) begin it = q0.pop_front(); hold0 = it.data; end
                chk("pcm", if0.pcm_data_out, hold0);

                exp_v = (q1.size() != 0) && (q1[0].cyc == cyc);
                chk("valid2", if1.pcm_valid, exp_v);
                if (exp_v) begin it = q1.pop_front(); hold1 = it.data; end
                chk("pcm2", if1.pcm_data_out, hold1);

                run_prev = if0.running;
                en_prev  = enable;
            end
        end
    end

    // Long frames on the second build: ones then zeros drive the saturation limits.
    initial begin
        pat1 = 0;
        go(9200);
        pat1 = 1;
        go(8500);
        pat1 = 4;
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; pat0 = 0;
        go(5);
        rst_n = 1'b1;
        go(100);
        enable = 1'b1;
        go(3500);
        pat0 = 1; go(2100);
        pat0 = 2; go(2100);
        pat0 = 3; go(2100);
        pat0 = 4; go(7500);
        enable = 1'b0; go(50);
        enable = 1'b1; go(3300);
        @(posedge clk);
        #3 rst_n = 1'b0;
        go(4);
        rst_n = 1'b1;
        go(2300);
        enable = 1'b0;
        go(20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pdm_cic_frontend.md
Name: pdm_cic_frontend

Overview:
- Multichannel PDM-to-PCM front end, directly upstream of the delay-and-sum beamformer.
- Generates the shared PDM bit clock for the mic array and samples one PDM data line per mic.
- Decimates each line by DECIM with a first-order CIC (ones counter per frame) and removes the DC offset.
- Presents one signed PCM sample per mic, packed, with a single-cycle valid strobe per output frame.

Parameters:
- BIT_WIDTH, 8, width of each output PCM sample (two's complement).
- NUM_MICS, 25, number of microphones / PDM data lines.
- CLK_DIV, 16, clk cycles per PDM clock period; even and >= 8.
- DECIM, 64, PDM bits per PCM sample; power of 2, >= 4.
- WARMUP_FRAMES, 1, output frames discarded after each start (mic settling).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  synchronous run request; level-sensitive.
- pdm_data  input  NUM_MICS  raw PDM bits, bit i = mic i; asynchronous to clk.
- pdm_clk_out  output  1  PDM bit clock to the mics, registered.
- pcm_data_out  output  NUM_MICS*BIT_WIDTH  mic i sample in bits [i*BIT_WIDTH +: BIT_WIDTH].
- pcm_valid  output  1  one-cycle strobe; pcm_data_out is updated in the same cycle.
- running  output  1  high in WARMUP or RUN.

Behaviour:
- Reset (rst_n low, async):
  - pdm_clk_out=0, pcm_data_out=0, pcm_valid=0, running=0.
  - State IDLE; all counters and accumulators cleared.
  - pdm_data synchroniser flops cleared.
- State machine (IDLE, WARMUP, RUN):
  - IDLE: enable=1 -> WARMUP on the next edge, with div_cnt=0, bit_cnt=0, frame_cnt=0.
  - WARMUP: after WARMUP_FRAMES completed frames -> RUN. If WARMUP_FRAMES=0, go directly from IDLE to RUN.
  - RUN: stays in RUN while enable=1.
  - enable=0 in WARMUP or RUN -> IDLE on the next edge. The partial frame is discarded, no pcm_valid is produced, and pcm_data_out holds its last value.
- PDM clock:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pdm_clk_out=1 when div_cnt >= CLK_DIV/2, otherwise 0.
  - Held low in IDLE.
- Sampling:
  - pdm_data passes through a 2-flop synchroniser per bit.
  - The synchronised bits are sampled on the edge where div_cnt==CLK_DIV-1 (end of the high phase).
  - CLK_DIV >= 8 guarantees these bits reflect data launched at least 1 clk after the rising PDM edge.
- Accumulation:
  - Per-mic ones counter, width clog2(DECIM+1).
  - Incremented by the sampled bit; bit_cnt counts 0..DECIM-1.
- Frame end (sample with bit_cnt==DECIM-1):
  - Per mic: value = count - DECIM/2, signed.
  - Saturate value to the signed BIT_WIDTH range [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1].
  - Counters restart at 0; the frame-end bit belongs to the finished frame.
- Output timing:
  - Frame f (1-based) last sample occurs at cycle f*DECIM*CLK_DIV-1 after entering WARMUP.
  - pcm_data_out and pcm_valid are registered on the next cycle: valid high at cycle f*DECIM*CLK_DIV.
  - Warmup frames update nothing and produce no pcm_valid.
- pcm_valid is high for exactly 1 cycle per RUN frame. pcm_data_out is stable between strobes.
- enable re-asserted in the same cycle IDLE is entered takes effect on the following edge (normal IDLE->WARMUP path).
- Reset mid-frame: immediate return to reset values; no partial output.

Test Plan:
1. Reset with defaults, enable=0 for 100 cycles -> pdm_clk_out, pcm_valid, running and pcm_data_out all 0.
2. Defaults, enable=1, pdm_data all 1 -> pdm_clk_out period 16 clk with 8 high; first pcm_valid exactly 2048 cycles after WARMUP entry; every lane = 0x20 (+32); subsequent valids every 1024 cycles.
3. pdm_data all 0 -> every lane 0xE0 (-32). Pattern alternating 1/0 per PDM bit -> every lane 0x00. Mic 3 all 1, others all 0 -> only lane 3 = 0x20, other lanes 0xE0.
4. BIT_WIDTH=8, DECIM=512, all 1s -> lanes saturate to 0x7F; all 0s -> lanes saturate to 0x80.
5. Drop enable mid-frame in RUN -> IDLE next cycle; no pcm_valid; pcm_data_out holds; pdm_clk_out low. Re-enable -> warmup repeats and the first valid comes 2048 cycles after re-entry.
6. Assert rst_n low during RUN between edges -> outputs 0 immediately (async). Release and enable -> same timing as scenario 2.
